// File: rtl/nts_dispatcher_scheduler.sv
// Drains frames from the dispatcher front buffer and streams each one as
// 64-bit beats to the next idle NTS engine, chosen round-robin.
// Ports:
//   i_clk, i_areset            clock, synchronous active-high reset
//   i_dispatch_*               front buffer status, length, last mask, rdata
//   o_dispatch_raddr           buffer read address (rdata one cycle later)
//   o_process_frame            one-cycle pulse releasing the front buffer
//   i_engine_busy              per-engine busy flags
//   o_engine_rx_*              beat strobe, data, byte mask and last marker
//   o_frames_dispatched        count of non-empty frames handed to engines
module nts_dispatcher_scheduler #(
  parameter int ADDR_WIDTH = 3,
  parameter int ENGINES    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_dispatch_packet_available,
  input  logic [ADDR_WIDTH-1:0] i_dispatch_counter,
  input  logic [7:0]            i_dispatch_data_valid,
  output logic [ADDR_WIDTH-1:0] o_dispatch_raddr,
  input  logic [63:0]           i_dispatch_rdata,
  output logic                  o_process_frame,
  input  logic [ENGINES-1:0]    i_engine_busy,
  output logic [ENGINES-1:0]    o_engine_rx_valid,
  output logic [63:0]           o_engine_rx_data,
  output logic [7:0]            o_engine_rx_data_valid,
  output logic                  o_engine_rx_last,
  output logic [31:0]           o_frames_dispatched
);

  localparam int PW = (ENGINES > 1) ? $clog2(ENGINES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_READ,
    S_RELEASE,
    S_WAIT_DROP
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [7:0]            m_q, m_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ENGINES-1:0]    valid_q, valid_d;
  logic [7:0]            mask_q, mask_d;
  logic                  last_q, last_d;
  logic                  pf_q, pf_d;
  logic [31:0]           frames_q, frames_d;

  logic                  found;
  logic [PW-1:0]         sel;
  logic [PW-1:0]         sel_nxt;
  logic [PW:0]           idx;

  // Rotating search: candidate ptr+i, wrapped explicitly so a
  // non-power-of-two engine count still cycles through every engine.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < ENGINES; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(ENGINES)) begin
        idx = idx - (PW+1)'(ENGINES);
      end
      if (!found && !i_engine_busy[idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
    sel_nxt = (sel == PW'(ENGINES-1)) ? '0 : sel + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    n_d      = n_q;
    m_d      = m_q;
    raddr_d  = raddr_q;
    valid_d  = '0;
    mask_d   = '0;
    last_d   = 1'b0;
    pf_d     = 1'b0;
    frames_d = frames_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_dispatch_packet_available) begin
          n_d = i_dispatch_counter;
          m_d = i_dispatch_data_valid;
          if (i_dispatch_counter == '0) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (found) begin
          grant_d = sel;
          ptr_d   = sel_nxt;
          raddr_d = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Beat flops fire the cycle after the address, lining up
        // with the buffer's one-cycle read latency.
        valid_d = ENGINES'(1) << grant_q;
        if (raddr_q == n_q - 1'b1) begin
          mask_d  = m_q;
          last_d  = 1'b1;
          state_d = S_RELEASE;
        end else begin
          mask_d  = 8'hFF;
          raddr_d = raddr_q + 1'b1;
        end
      end
      S_RELEASE: begin
        pf_d = 1'b1;
        if (n_q != '0) begin
          frames_d = frames_q + 32'd1;
        end
        state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        // The front keeps available high until it has seen the
        // release; waiting here stops a double dispatch.
        if (!i_dispatch_packet_available) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      n_q      <= '0;
      m_q      <= '0;
      raddr_q  <= '0;
      valid_q  <= '0;
      mask_q   <= '0;
      last_q   <= 1'b0;
      pf_q     <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      n_q      <= n_d;
      m_q      <= m_d;
      raddr_q  <= raddr_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      last_q   <= last_d;
      pf_q     <= pf_d;
      frames_q <= frames_d;
    end
  end

  assign o_dispatch_raddr       = raddr_q;
  assign o_process_frame        = pf_q;
  assign o_engine_rx_valid      = valid_q;
  assign o_engine_rx_data       = (|valid_q) ? i_dispatch_rdata : '0;
  assign o_engine_rx_data_valid = mask_q;
  assign o_engine_rx_last       = last_q;
  assign o_frames_dispatched    = frames_q;

endmodule
